cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Parametrised successor to the combinational exception prioritiser. Owns the CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) and the Count/Compare timer. Prioritises and commits exceptions/interrupts at the M stage, holds them while the pipeline is stalled, and drives flush plus redirect PC. Sits beside the M stage of the 5-stage MIPS pipeline, replacing the separate exception block and CP0.

Parameters:
HW_INT_NUM, 6, number of external hardware interrupt lines (1..6) mapped to Cause.IP[2+HW_INT_NUM-1:2]
EXC_VEC, 32'hBFC0_0380, general exception entry address
COUNT_DIV, 2, clock cycles per Count increment (power of two, >=1)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
stall_m  in  1  longest pipeline stall; M stage frozen when 1
exc_vec_m  in  8  bits 7..2 = fetch-AdEL, syscall, break, eret, RI, Ov; bits 1..0 reserved
adel_m  in  1  data load address error
ades_m  in  1  data store address error
pc_m  in  32  PC of M-stage instruction
dvaddr_m  in  32  data virtual address of M-stage load/store
bd_m  in  1  M-stage instruction is in a branch delay slot
hw_int  in  HW_INT_NUM  external interrupt levels
cp0_we  in  1  MTC0 write enable (M stage)
cp0_waddr  in  5  MTC0 register number
cp0_wdata  in  32  MTC0 data
cp0_raddr  in  5  MFC0 register number
cp0_rdata  out  32  MFC0 read data (combinational)
exc_valid  out  1  exception/interrupt/eret committed this cycle
exc_type  out  32  1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 0xE eret, 0xA RI, 0xC Ov, else 0
flush  out  1  equals exc_valid
pc_new  out  32  redirect target; 0 when !exc_valid
timer_int  out  1  Cause.TI

Behaviour:
- Reset (resetn=0 at posedge): Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, divider=0; outputs exc_valid=0, exc_type=0, pc_new=0, timer_int=0.
- Priority (combinational): int > AdEL (fetch or data) > AdES > Sys > Bp > eret > RI > Ov. Int pending = |(Cause.IP & Status.IM) & Status.IE & !Status.EXL.
- Cause.IP[7] = TI; IP[2+:HW_INT_NUM] sampled from hw_int each cycle (registered, 1-cycle latency); IP[1:0] software, writable via MTC0.
- Commit only when stall_m=0; exc_valid=0 whenever stall_m=1, causes stay pending, CP0 state other than Count/divider/IP untouched.
- On commit (non-eret): EPC = bd_m ? pc_m-4 : pc_m; Cause.BD=bd_m; Cause.ExcCode=exc_type[4:0]; Status.EXL=1; pc_new=EXC_VEC. AdEL-fetch: BadVAddr=pc_m; AdEL/AdES data: BadVAddr=dvaddr_m. If EXL already 1, EPC/BD unchanged.
- Eret commit: Status.EXL=0, pc_new=EPC (register value).
- MTC0 applies at posedge when cp0_we & !stall_m & !exc_valid; exception suppresses same-cycle write. Writable masks: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Compare, Count full. Others read-only.
- Timer: Count += 1 every COUNT_DIV cycles (wraps 0xFFFF_FFFF->0, runs during stall). TI set when Count==Compare (Compare!=0 not required); cleared by any Compare write. Count write resets divider.
- Simultaneous Count increment and Count write: write wins.
- cp0_rdata returns current register value; unmapped numbers read 0.

Optional Feature:
CP0_FWD_EN: when defined, a same-cycle MTC0 to Status/Cause/EPC (cp0_we & !stall_m) is forwarded into the interrupt check and eret pc_new (eret to freshly written EPC returns cp0_wdata). When undefined, checks use registered values only; the written value is visible one cycle later.

Decomposition:
- Package cp0_pkg: register numbers (8,9,11,12,13,14), ExcCode constants, Status/Cause bit-field indices, Status reset value.
- Sub-module cp0_timer: Count, divider, Compare, TI; interfaces: write strobes, wdata, count/compare/ti outputs.

Test Plan:
- Reset then Status read -> cp0_rdata=32'h0040_0000, exc_valid=0, pc_new=0.
- Syscall at pc_m=0xBFC0_0100, bd_m=1 -> exc_valid=1, exc_type=8, pc_new=0xBFC0_0380; next cycle EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=8, EXL=1.
- Data AdES (dvaddr_m=0x8000_0003) with stall_m=1 for 3 cycles -> exc_valid=0 throughout; first unstalled cycle exc_type=5, BadVAddr=0x8000_0003.
- Compare=5, COUNT_DIV=2, Status IM7=1, IE=1 -> Count reaches 5 at cycle 10, TI=1, exc_type=1 next cycle; Compare write clears TI.
- EXL=1, then eret with EPC=0xBFC0_0200 -> pc_new=0xBFC0_0200, EXL=0; with CP0_FWD_EN, same-cycle MTC0 EPC=0x1234 -> pc_new=0x1234.
- hw_int[0]=1, IM2=0 -> no interrupt; MTC0 Status IM2=1,IE=1 -> exc_type=1 (same cycle with CP0_FWD_EN, one cycle later without).

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field positions
// and the Status reset value. Imported by the timer and the top.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_NONE = 5'h00,
    EXC_INT  = 5'h01,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C,
    EXC_ERET = 5'h0E
  } exc_code_e;

  // Bit positions inside exc_vec_m
  localparam int EV_ADEL_IF = 7;
  localparam int EV_SYS     = 6;
  localparam int EV_BP      = 5;
  localparam int EV_ERET    = 4;
  localparam int EV_RI      = 3;
  localparam int EV_OV      = 2;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;

  localparam int CA_IP_LO = 8;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage pipeline <-> CP0/exception controller bundle: exception sources, MTC0/MFC0
// access and the commit/redirect outputs.
interface cp0_exc_ctrl_if;
  logic        stall_m;
  logic [7:0]  exc_vec_m;
  logic        adel_m;
  logic        ades_m;
  logic [31:0] pc_m;
  logic [31:0] dvaddr_m;
  logic        bd_m;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        exc_valid;
  logic [31:0] exc_type;
  logic        flush;
  logic [31:0] pc_new;

  modport master (
    output stall_m, exc_vec_m, adel_m, ades_m, pc_m, dvaddr_m, bd_m,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, exc_valid, exc_type, flush, pc_new
  );

  modport slave (
    input  stall_m, exc_vec_m, adel_m, ades_m, pc_m, dvaddr_m, bd_m,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, exc_valid, exc_type, flush, pc_new
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every COUNT_DIV cycles (also during stalls),
// TI latches on Count==Compare and clears on any Compare write.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // A Count write wins over the increment and restarts the prescaler
      if (count_we) begin
        count <= wdata;
        div_q <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
        if (tick) count <= count + 32'd1;
      end

      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file plus M-stage exception prioritiser/commit. Optional macro CP0_FWD_EN
// forwards a same-cycle MTC0 of Status/Cause/EPC into the interrupt check and eret target.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  cp0_exc_ctrl_if.slave         pipe,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic                  timer_int
);

  logic [7:0]  st_im;
  logic        st_exl;
  logic        st_ie;
  logic [1:0]  sw_ip;
  logic [5:0]  hw_ip;
  logic [5:0]  hw_ext;
  logic        ca_bd;
  logic [4:0]  ca_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [7:0]  ip;

  logic [7:0]  im_eff;
  logic        ie_eff;
  logic        exl_eff;
  logic [1:0]  sw_eff;
  logic [31:0] epc_eff;
  logic        int_pend;

  exc_code_e   cause;
  logic        bad_fetch;
  logic        bad_data;
  logic        exc_valid;
  logic        wr_ok;
  logic        unused_rsv;

  assign unused_rsv = ^pipe.exc_vec_m[1:0];

  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_NUM-1:0] = hw_int;
  end

  // The top hardware line shares IP7 with the timer
  assign ip = {ti | hw_ip[5], hw_ip[4:0], sw_ip};

`ifdef CP0_FWD_EN
  logic fwd_we;
  assign fwd_we = pipe.cp0_we & ~pipe.stall_m;

  always_comb begin
    im_eff  = st_im;
    ie_eff  = st_ie;
    exl_eff = st_exl;
    sw_eff  = sw_ip;
    epc_eff = epc;
    if (fwd_we) begin
      case (pipe.cp0_waddr)
        REG_STATUS: begin
          im_eff  = pipe.cp0_wdata[ST_IM_LO +: 8];
          ie_eff  = pipe.cp0_wdata[ST_IE];
          exl_eff = pipe.cp0_wdata[ST_EXL];
        end
        REG_CAUSE: sw_eff  = pipe.cp0_wdata[CA_IP_LO +: 2];
        REG_EPC:   epc_eff = pipe.cp0_wdata;
        default: ;
      endcase
    end
  end
`else
  always_comb begin
    im_eff  = st_im;
    ie_eff  = st_ie;
    exl_eff = st_exl;
    sw_eff  = sw_ip;
    epc_eff = epc;
  end
`endif

  assign int_pend = (|({ip[7:2], sw_eff} & im_eff)) & ie_eff & ~exl_eff;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    cause     = EXC_NONE;
    bad_fetch = 1'b0;
    bad_data  = 1'b0;
    if (int_pend) begin
      cause = EXC_INT;
    end else if (pipe.exc_vec_m[EV_ADEL_IF]) begin
      cause     = EXC_ADEL;
      bad_fetch = 1'b1;
    end else if (pipe.adel_m) begin
      cause    = EXC_ADEL;
      bad_data = 1'b1;
    end else if (pipe.ades_m) begin
      cause    = EXC_ADES;
      bad_data = 1'b1;
    end else if (pipe.exc_vec_m[EV_SYS]) begin
      cause = EXC_SYS;
    end else if (pipe.exc_vec_m[EV_BP]) begin
      cause = EXC_BP;
    end else if (pipe.exc_vec_m[EV_ERET]) begin
      cause = EXC_ERET;
    end else if (pipe.exc_vec_m[EV_RI]) begin
      cause = EXC_RI;
    end else if (pipe.exc_vec_m[EV_OV]) begin
      cause = EXC_OV;
    end
  end

  assign exc_valid      = resetn & ~pipe.stall_m & (cause != EXC_NONE);
  assign pipe.exc_valid = exc_valid;
  assign pipe.flush     = exc_valid;
  assign pipe.exc_type  = exc_valid ? {27'd0, cause} : 32'd0;
  assign pipe.pc_new    = !exc_valid          ? 32'd0   :
                          (cause == EXC_ERET) ? epc_eff : EXC_VEC;
  assign timer_int      = ti;

  // A committing exception swallows the MTC0 in the same M-stage slot
  assign wr_ok = pipe.cp0_we & ~pipe.stall_m & ~exc_valid;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr_ok && pipe.cp0_waddr == REG_COUNT),
    .compare_we (wr_ok && pipe.cp0_waddr == REG_COMPARE),
    .wdata      (pipe.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_im    <= '0;
      st_exl   <= 1'b0;
      st_ie    <= 1'b0;
      sw_ip    <= '0;
      hw_ip    <= '0;
      ca_bd    <= 1'b0;
      ca_exc   <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      hw_ip <= hw_ext;
      if (exc_valid) begin
        if (cause == EXC_ERET) begin
          st_exl <= 1'b0;
        end else begin
          // A nested exception keeps the original return point
          if (!st_exl) begin
            epc   <= pipe.bd_m ? pipe.pc_m - 32'd4 : pipe.pc_m;
            ca_bd <= pipe.bd_m;
          end
          ca_exc <= cause;
          st_exl <= 1'b1;
          if (bad_fetch)     badvaddr <= pipe.pc_m;
          else if (bad_data) badvaddr <= pipe.dvaddr_m;
        end
      end else if (wr_ok) begin
        case (pipe.cp0_waddr)
          REG_STATUS: begin
            st_im  <= pipe.cp0_wdata[ST_IM_LO +: 8];
            st_exl <= pipe.cp0_wdata[ST_EXL];
            st_ie  <= pipe.cp0_wdata[ST_IE];
          end
          REG_CAUSE: sw_ip <= pipe.cp0_wdata[CA_IP_LO +: 2];
          REG_EPC:   epc   <= pipe.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (pipe.cp0_raddr)
      REG_BADVADDR: pipe.cp0_rdata = badvaddr;
      REG_COUNT:    pipe.cp0_rdata = count;
      REG_COMPARE:  pipe.cp0_rdata = compare;
      REG_STATUS:   pipe.cp0_rdata = {9'd0, 1'b1, 6'd0, st_im, 6'd0, st_exl, st_ie};
      REG_CAUSE:    pipe.cp0_rdata = {ca_bd, ti, 14'd0, ip, 1'b0, ca_exc, 2'b00};
      REG_EPC:      pipe.cp0_rdata = epc;
      default:      pipe.cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: priority table, hand-written timing sequences and a randomized run
// against a register-level reference model.
module tb_cp0_exc_ctrl;

  localparam int          HW_INT_NUM = 6;
  localparam logic [31:0] EXC_VEC    = 32'hBFC0_0380;
  localparam int          COUNT_DIV  = 2;

  typedef struct packed {
    bit        stall;
    bit [7:0]  ev;
    bit        adel;
    bit        ades;
    bit [31:0] pc;
    bit [31:0] dva;
    bit        bd;
    bit [5:0]  hw;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit [4:0]  ra;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit        valid;
    bit [31:0] typ;
    bit [31:0] pcn;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [HW_INT_NUM-1:0] hw_int;
  logic                  timer_int;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(
    .HW_INT_NUM (HW_INT_NUM),
    .EXC_VEC    (EXC_VEC),
    .COUNT_DIV  (COUNT_DIV)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pipe      (bus),
    .hw_int    (hw_int),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (architectural CP0 view)
  bit [7:0]  m_im;
  bit        m_ie, m_exl, m_bd, m_ti;
  bit [1:0]  m_sw;
  bit [5:0]  m_hwq;
  bit [4:0]  m_code;
  bit [31:0] m_epc, m_bva, m_cmp, m_cbase;
  longint    m_ticks;

  bit        e_valid;
  bit [31:0] e_type, e_pc, e_rdata;
  stim_t     cur;
  bit [5:0]  hw_state;
  bit [4:0]  regs[8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd21};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] m_count();
    return m_cbase + 32'(m_ticks / COUNT_DIV);
  endfunction

  task automatic model_reset();
    m_im = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_sw = '0; m_hwq = '0;
    m_code = '0; m_epc = '0; m_bva = '0; m_cmp = '0; m_cbase = '0; m_ticks = 0;
  endtask

  task automatic model_eval(input stim_t s);
    bit [7:0]  im  = m_im;
    bit        ie  = m_ie;
    bit        exl = m_exl;
    bit [1:0]  sw  = m_sw;
    bit [31:0] epc = m_epc;
    bit [7:0]  ip, ip_reg;
    bit        hit[8];
    bit [4:0]  codes[8] = '{5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd14, 5'd10, 5'd12};
    bit [4:0]  code = 0;
`ifdef CP0_FWD_EN
    if (s.we && !s.stall) begin
      if (s.wa == 12) begin im = s.wd[15:8]; exl = s.wd[1]; ie = s.wd[0]; end
      if (s.wa == 13) sw = s.wd[9:8];
      if (s.wa == 14) epc = s.wd;
    end
`endif
    ip_reg = {m_ti | m_hwq[5], m_hwq[4:0], m_sw};
    ip     = {ip_reg[7:2], sw};
    hit = '{(|(ip & im)) && ie && !exl, s.ev[7] || s.adel, s.ades,
            s.ev[6], s.ev[5], s.ev[4], s.ev[3], s.ev[2]};
    for (int i = 0; i < 8; i++)
      if (hit[i] && code == 0) code = codes[i];
    e_valid = !s.stall && code != 0;
    e_type  = e_valid ? {27'd0, code} : 32'd0;
    e_pc    = !e_valid ? 32'd0 : (code == 14) ? epc : EXC_VEC;
    case (s.ra)
      5'd8:    e_rdata = m_bva;
      5'd9:    e_rdata = m_count();
      5'd11:   e_rdata = m_cmp;
      5'd12:   e_rdata = {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   e_rdata = {m_bd, m_ti, 14'd0, ip_reg, 1'b0, m_code, 2'b00};
      5'd14:   e_rdata = m_epc;
      default: e_rdata = 32'd0;
    endcase
  endtask

  task automatic model_update(input stim_t s);
    bit        wr  = s.we && !s.stall && !e_valid;
    bit [31:0] cnt = m_count();
    if (wr && s.wa == 11) begin m_cmp = s.wd; m_ti = 0; end
    else if (cnt == m_cmp) m_ti = 1;
    m_ticks++;
    if (wr && s.wa == 9) begin m_cbase = s.wd; m_ticks = 0; end
    if (e_valid) begin
      if (e_type == 14) m_exl = 0;
      else begin
        if (!m_exl) begin m_epc = s.bd ? s.pc - 32'd4 : s.pc; m_bd = s.bd; end
        m_code = e_type[4:0];
        m_exl  = 1;
        if (e_type == 4) m_bva = s.ev[7] ? s.pc : s.dva;
        if (e_type == 5) m_bva = s.dva;
      end
    end
    if (wr) begin
      if (s.wa == 12) begin m_im = s.wd[15:8]; m_exl = s.wd[1]; m_ie = s.wd[0]; end
      if (s.wa == 13) m_sw = s.wd[9:8];
      if (s.wa == 14) m_epc = s.wd;
    end
    m_hwq = s.hw;
  endtask

  task automatic drive(input stim_t s);
    cur           = s;
    bus.stall_m   = s.stall;
    bus.exc_vec_m = s.ev;
    bus.adel_m    = s.adel;
    bus.ades_m    = s.ades;
    bus.pc_m      = s.pc;
    bus.dvaddr_m  = s.dva;
    bus.bd_m      = s.bd;
    bus.cp0_we    = s.we;
    bus.cp0_waddr = s.wa;
    bus.cp0_wdata = s.wd;
    bus.cp0_raddr = s.ra;
    hw_int        = s.hw[HW_INT_NUM-1:0];
    #1;
    model_eval(s);
  endtask

  task automatic clock();
    @(posedge clk);
    if (resetn) model_update(cur);
    else model_reset();
    @(negedge clk);
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t wr(input bit [4:0] a, input bit [31:0] d);
    stim_t s = '0;
    s.we = 1; s.wa = a; s.wd = d;
    return s;
  endfunction

  function automatic stim_t rd(input bit [4:0] a);
    stim_t s = '0;
    s.ra = a;
    return s;
  endfunction

  function automatic stim_t exc(input bit stall, input bit [7:0] ev, input bit adel, input bit ades);
    stim_t s = '0;
    s.stall = stall; s.ev = ev; s.adel = adel; s.ades = ades;
    s.pc = 32'h8000_1000; s.dva = 32'h1234_5678;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s = idle();
    resetn = 1'b0;
    s.ev = 8'h40;
    drive(s);
    check("rst_valid", bus.exc_valid, 1'b0);
    check("rst_pcnew", bus.pc_new, 32'd0);
    clock();
    clock();
    resetn = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, bus.exc_valid, e_valid);
    check({tag, "_flush"}, bus.flush, e_valid);
    check({tag, "_type"},  bus.exc_type, e_type);
    check({tag, "_pcnew"}, bus.pc_new, e_pc);
    check({tag, "_rdata"}, bus.cp0_rdata, e_rdata);
    check({tag, "_ti"},    timer_int, m_ti);
  endtask

  vec_t  tbl[12];
  stim_t s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---------- reset state ----------
    do_reset();
    drive(rd(12));
    check("reset_status", bus.cp0_rdata, 32'h0040_0000);
    check("reset_valid", bus.exc_valid, 1'b0);
    check("reset_type", bus.exc_type, 32'd0);
    check("reset_pcnew", bus.pc_new, 32'd0);
    check("reset_ti", timer_int, 1'b0);
    drive(rd(13));
    check("reset_cause", bus.cp0_rdata, 32'd0);
    clock();

    // ---------- priority table (interrupts disabled) ----------
    tbl[0]  = '{exc(0, 8'h40, 0, 0), 1, 32'h08, EXC_VEC};
    tbl[1]  = '{exc(0, 8'hA0, 0, 0), 1, 32'h04, EXC_VEC};
    tbl[2]  = '{exc(0, 8'h00, 1, 1), 1, 32'h04, EXC_VEC};
    tbl[3]  = '{exc(0, 8'h40, 0, 1), 1, 32'h05, EXC_VEC};
    tbl[4]  = '{exc(0, 8'h28, 0, 0), 1, 32'h09, EXC_VEC};
    tbl[5]  = '{exc(0, 8'h0C, 0, 0), 1, 32'h0A, EXC_VEC};
    tbl[6]  = '{exc(0, 8'h04, 0, 0), 1, 32'h0C, EXC_VEC};
    tbl[7]  = '{exc(1, 8'h40, 0, 0), 0, 32'h00, 32'd0};
    tbl[8]  = '{exc(0, 8'h00, 0, 0), 0, 32'h00, 32'd0};
    tbl[9]  = '{exc(0, 8'h03, 0, 0), 0, 32'h00, 32'd0};
    tbl[10] = '{exc(0, 8'h50, 0, 0), 1, 32'h08, EXC_VEC};
    tbl[11] = '{exc(0, 8'h7C, 0, 0), 1, 32'h08, EXC_VEC};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].s);
      check($sformatf("tbl%0d_valid", i), bus.exc_valid, tbl[i].valid);
      check($sformatf("tbl%0d_type", i), bus.exc_type, tbl[i].typ);
      check($sformatf("tbl%0d_pcnew", i), bus.pc_new, tbl[i].pcn);
      clock();
    end

    // ---------- syscall in delay slot ----------
    do_reset();
    s = idle(); s.ev = 8'h40; s.pc = 32'hBFC0_0100; s.bd = 1;
    drive(s);
    check("sys_valid", bus.exc_valid, 1'b1);
    check("sys_flush", bus.flush, 1'b1);
    check("sys_type", bus.exc_type, 32'h8);
    check("sys_pcnew", bus.pc_new, 32'hBFC0_0380);
    clock();
    drive(rd(14));
    check("sys_epc", bus.cp0_rdata, 32'hBFC0_00FC);
    clock();
    drive(rd(13));
    check("sys_cause_bd_code", bus.cp0_rdata & 32'h8000_007C, 32'h8000_0020);
    clock();
    drive(rd(12));
    check("sys_status_exl", bus.cp0_rdata, 32'h0040_0002);
    clock();

    // ---------- AdES held across stall ----------
    do_reset();
    s = idle(); s.ades = 1; s.dva = 32'h8000_0003; s.stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(s);
      check($sformatf("ades_stall%0d_valid", i), bus.exc_valid, 1'b0);
      check($sformatf("ades_stall%0d_pcnew", i), bus.pc_new, 32'd0);
      clock();
    end
    s.stall = 0;
    drive(s);
    check("ades_valid", bus.exc_valid, 1'b1);
    check("ades_type", bus.exc_type, 32'h5);
    clock();
    drive(rd(8));
    check("ades_badvaddr", bus.cp0_rdata, 32'h8000_0003);
    clock();

    // ---------- timer interrupt ----------
    do_reset();
    drive(wr(11, 32'd5)); clock();           // posedge 1
    drive(wr(12, 32'h0000_8001)); clock();   // posedge 2
    for (int k = 3; k <= 10; k++) begin
      drive(idle());
      clock();
    end
    drive(rd(9));
    check("tmr_count5", bus.cp0_rdata, 32'd5);
    check("tmr_ti_before", timer_int, 1'b0);
    check("tmr_valid_before", bus.exc_valid, 1'b0);
    clock();                                  // posedge 11
    drive(idle());
    check("tmr_ti", timer_int, 1'b1);
    check("tmr_valid", bus.exc_valid, 1'b1);
    check("tmr_type", bus.exc_type, 32'h1);
    check("tmr_pcnew", bus.pc_new, EXC_VEC);
    clock();
    drive(wr(11, 32'h100)); clock();
    drive(idle());
    check("tmr_ti_cleared", timer_int, 1'b0);
    clock();

    // ---------- eret ----------
    do_reset();
    drive(wr(14, 32'hBFC0_0200)); clock();
    drive(wr(12, 32'h2)); clock();
    drive(rd(12));
    check("eret_exl_set", bus.cp0_rdata, 32'h0040_0002);
    clock();
    s = idle(); s.ev = 8'h10;
    drive(s);
    check("eret_type", bus.exc_type, 32'hE);
    check("eret_pcnew", bus.pc_new, 32'hBFC0_0200);
    clock();
    drive(rd(12));
    check("eret_exl_clr", bus.cp0_rdata, 32'h0040_0000);
    clock();
    s = wr(14, 32'h1234); s.ev = 8'h10;
    drive(s);
`ifdef CP0_FWD_EN
    check("eret_fwd_pcnew", bus.pc_new, 32'h1234);
`else
    check("eret_nofwd_pcnew", bus.pc_new, 32'hBFC0_0200);
`endif
    clock();
    drive(rd(14));
    check("eret_epc_kept", bus.cp0_rdata, 32'hBFC0_0200);
    clock();

    // ---------- hardware interrupt masking ----------
    do_reset();
    s = idle(); s.hw = 6'd1;
    drive(s); clock();
    drive(s);
    check("hw_masked", bus.exc_valid, 1'b0);
    clock();
    s = wr(12, 32'h0000_0401); s.hw = 6'd1;
    drive(s);
`ifdef CP0_FWD_EN
    check("hw_fwd_valid", bus.exc_valid, 1'b1);
    check("hw_fwd_type", bus.exc_type, 32'h1);
`else
    check("hw_nofwd_valid", bus.exc_valid, 1'b0);
`endif
    clock();
    s = idle(); s.hw = 6'd1;
    drive(s);
`ifdef CP0_FWD_EN
    check("hw_fwd_after", bus.exc_valid, 1'b0);
`else
    check("hw_late_valid", bus.exc_valid, 1'b1);
    check("hw_late_type", bus.exc_type, 32'h1);
`endif
    clock();

    // ---------- randomized run against the model ----------
    do_reset();
    hw_state = '0;
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.stall = ($urandom_range(3) == 0);
      s.ev    = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      s.adel  = ($urandom_range(15) == 0);
      s.ades  = ($urandom_range(15) == 0);
      s.pc    = $urandom;
      s.dva   = $urandom;
      s.bd    = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) hw_state = 6'($urandom);
      s.hw    = hw_state;
      s.we    = ($urandom_range(2) == 0);
      s.wa    = regs[$urandom_range(7)];
      s.wd    = $urandom;
      if (s.wa == 11 && $urandom_range(1) == 1) s.wd = m_count() + $urandom_range(3);
      if (s.wa == 12) s.wd[1] = ($urandom_range(3) == 0);
      s.ra    = regs[$urandom_range(7)];
      drive(s);
      check_model($sformatf("rnd%0d", n));
      clock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
